// File: rtl/alu_sequencer.sv
// Accumulator sequencer that issues one instruction at a time to an external ALU and holds the result.
// Define ALU_SEQ_SATURATE_EN to clamp ADD/SUB results on carry/borrow instead of wrapping.
`timescale 1ns/1ps

module alu_sequencer_chk #(
  parameter int DATA_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  input logic [6:0]            ctrl,
  input logic                  instr_ready,
  input logic                  result_valid,
  input logic [DATA_WIDTH-1:0] alu_in1,
  input logic [DATA_WIDTH-1:0] alu_in2
);

  a_ctrl_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(ctrl));

  a_handshake_excl: assert property (@(posedge clk) disable iff (rst) !(instr_ready && result_valid));

  a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
    instr_ready |-> (ctrl == 7'b0000000 && alu_in1 == {DATA_WIDTH{1'b0}} && alu_in2 == {DATA_WIDTH{1'b0}}));

endmodule

module alu_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LOGIC_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic                  alu_add,
  output logic                  alu_sub,
  output logic                  alu_and,
  output logic                  alu_or,
  output logic                  alu_xor,
  output logic                  alu_inv,
  output logic                  alu_clr,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_overflow,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  flag_zero,
  output logic                  flag_overflow,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_INV  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_LOAD = 3'd7;

  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};
`ifdef ALU_SEQ_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] ONES = {DATA_WIDTH{1'b1}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Control line order is {clr, inv, xor, or, and, sub, add}; LOAD bypasses the ALU.
  function automatic logic [6:0] ctrl_decode(input logic [2:0] op);
    logic [6:0] lines;
    lines = 7'b0000000;
    case (op)
      OP_ADD:  lines = 7'b0000001;
      OP_SUB:  lines = 7'b0000010;
      OP_AND:  lines = 7'b0000100;
      OP_OR:   lines = 7'b0001000;
      OP_XOR:  lines = 7'b0010000;
      OP_INV:  lines = 7'b0100000;
      OP_CLR:  lines = 7'b1000000;
      default: lines = 7'b0000000;
    endcase
    return lines;
  endfunction

  state_e                  state_q, state_d;
  logic [2:0]              opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0]   operand_q, operand_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic                    flag_zero_q, flag_zero_d;
  logic                    flag_ovf_q, flag_ovf_d;
  logic [6:0]              ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]   alu_in1_q, alu_in1_d;
  logic [DATA_WIDTH-1:0]   alu_in2_q, alu_in2_d;
  logic                    instr_ready_q, instr_ready_d;
  logic                    result_valid_q, result_valid_d;

  logic [DATA_WIDTH-1:0]   logic_ext_s;
  logic [DATA_WIDTH-1:0]   exec_result_s;
  logic                    exec_ovf_s;

  assign logic_ext_s = {{(DATA_WIDTH-LOGIC_WIDTH){1'b0}}, alu_out[LOGIC_WIDTH-1:0]};

  // Value and overflow the accumulator takes when the instruction in ISSUE retires.
  always_comb begin
    exec_result_s = acc_q;
    exec_ovf_s    = 1'b0;
    case (opcode_q)
      OP_ADD: begin
        exec_ovf_s = alu_overflow;
`ifdef ALU_SEQ_SATURATE_EN
        if (alu_overflow) begin
          exec_result_s = ONES;
        end else begin
          exec_result_s = alu_out;
        end
`else
        exec_result_s = alu_out;
`endif
      end
      OP_SUB: begin
        exec_ovf_s = alu_overflow;
`ifdef ALU_SEQ_SATURATE_EN
        if (alu_overflow) begin
          exec_result_s = ZERO;
        end else begin
          exec_result_s = alu_out;
        end
`else
        exec_result_s = alu_out;
`endif
      end
      OP_AND, OP_OR, OP_XOR, OP_INV, OP_CLR: exec_result_s = logic_ext_s;
      OP_LOAD: exec_result_s = operand_q;
      default: exec_result_s = acc_q;
    endcase
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    operand_d      = operand_q;
    acc_d          = acc_q;
    flag_zero_d    = flag_zero_q;
    flag_ovf_d     = flag_ovf_q;
    ctrl_d         = 7'b0000000;
    alu_in1_d      = ZERO;
    alu_in2_d      = ZERO;
    instr_ready_d  = 1'b0;
    result_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          state_d   = ST_ISSUE;
          opcode_d  = opcode;
          operand_d = operand;
          ctrl_d    = ctrl_decode(opcode);
          alu_in1_d = acc_q;
          alu_in2_d = operand;
        end else begin
          instr_ready_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d        = ST_HOLD;
        acc_d          = exec_result_s;
        flag_ovf_d     = exec_ovf_s;
        flag_zero_d    = (exec_result_s == ZERO);
        result_valid_d = 1'b1;
      end
      ST_HOLD: begin
        if (result_ready) begin
          state_d       = ST_IDLE;
          instr_ready_d = 1'b1;
        end else begin
          result_valid_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        instr_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      opcode_q       <= 3'd0;
      operand_q      <= ZERO;
      acc_q          <= ZERO;
      flag_zero_q    <= 1'b0;
      flag_ovf_q     <= 1'b0;
      ctrl_q         <= 7'b0000000;
      alu_in1_q      <= ZERO;
      alu_in2_q      <= ZERO;
      instr_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      operand_q      <= operand_d;
      acc_q          <= acc_d;
      flag_zero_q    <= flag_zero_d;
      flag_ovf_q     <= flag_ovf_d;
      ctrl_q         <= ctrl_d;
      alu_in1_q      <= alu_in1_d;
      alu_in2_q      <= alu_in2_d;
      instr_ready_q  <= instr_ready_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign {alu_clr, alu_inv, alu_xor, alu_or, alu_and, alu_sub, alu_add} = ctrl_q;
  assign alu_in1       = alu_in1_q;
  assign alu_in2       = alu_in2_q;
  assign acc           = acc_q;
  assign flag_zero     = flag_zero_q;
  assign flag_overflow = flag_ovf_q;
  assign instr_ready   = instr_ready_q;
  assign result_valid  = result_valid_q;

  alu_sequencer_chk #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_chk (
    .clk          (clk),
    .rst          (rst),
    .ctrl         (ctrl_q),
    .instr_ready  (instr_ready_q),
    .result_valid (result_valid_q),
    .alu_in1      (alu_in1_q),
    .alu_in2      (alu_in2_q)
  );

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of accumulator, operand and ALU data buses.
REQ-002 Parameter LOGIC_WIDTH, default 4, width of the ALU logic-op result, which is zero-extended to DATA_WIDTH.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high, ports clk and rst.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 instr_valid  input  1  instruction present; instr_ready  output  1  sequencer can accept.
REQ-007 opcode  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INV, 6 CLR, 7 LOAD.
REQ-008 operand  input  DATA_WIDTH  second operand, or load value for LOAD.
REQ-009 alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_inv, alu_clr  output  1 each  one-hot ALU control lines.
REQ-010 alu_in1, alu_in2  output  DATA_WIDTH  ALU operands; alu_out  input  DATA_WIDTH; alu_overflow  input  1  carry (ADD) / borrow (SUB).
REQ-011 acc  output  DATA_WIDTH  accumulator; flag_zero, flag_overflow  output  1 each.
REQ-012 result_valid  output  1  result held; result_ready  input  1  consumer accepts.

Function
REQ-013 FSM states IDLE, ISSUE, HOLD; reset state IDLE.
REQ-014 IDLE: instr_ready=1; on instr_valid&&instr_ready, opcode and operand are registered and the FSM moves to ISSUE; otherwise it stays in IDLE.
REQ-015 instr_ready SHALL be 0 in ISSUE and HOLD; instr_valid is ignored there and no instruction is captured.
REQ-016 ISSUE: exactly the control line for the registered opcode is 1, all others 0; LOAD and non-ISSUE states drive all seven lines 0.
REQ-017 ISSUE: alu_in1=acc, alu_in2=registered operand; outside ISSUE both SHALL be 0.
REQ-018 At the ISSUE->HOLD edge, acc takes alu_out (ops 0-6) or the registered operand (LOAD); FSM moves to HOLD unconditionally.
REQ-019 flag_overflow updates at the same edge: alu_overflow for ADD/SUB, 0 for every other opcode.
REQ-020 flag_zero updates at the same edge: 1 iff the new acc value is 0.
REQ-021 HOLD: result_valid=1; acc and flags stable; on result_ready=1 the FSM moves to IDLE; otherwise it stays in HOLD indefinitely.
REQ-022 Latency: instruction accepted at edge N; acc/flags valid and result_valid=1 after edge N+1; earliest next accept at edge N+3 if result_ready is held high.
REQ-023 result_valid SHALL be 0 in IDLE and ISSUE.
REQ-024 Arithmetic wraps modulo 2^DATA_WIDTH (unless REQ-030); logic results occupy acc[LOGIC_WIDTH-1:0] with upper bits 0.

Reset
REQ-025 rst=1 at a rising edge forces IDLE, acc=0, flag_zero=0, flag_overflow=0, and clears the registered opcode/operand, regardless of state.
REQ-026 During and after reset: all ALU control lines 0, alu_in1/alu_in2 0, result_valid 0, instr_ready 1.
REQ-027 Reset asserted in ISSUE or HOLD SHALL discard the in-flight result; no acc update occurs at that edge.
REQ-028 rst has priority over instr_valid and result_ready at the same edge.

Configuration
REQ-029 Macro ALU_SEQ_SATURATE_EN selects saturating arithmetic.
REQ-030 Defined: ADD with alu_overflow=1 loads acc with all-ones; SUB with alu_overflow=1 loads acc with 0; flag_overflow still records alu_overflow; flag_zero follows the saturated value.
REQ-031 Undefined: acc takes alu_out unmodified (wrap-around); all other behaviour identical.

Verification
REQ-032 Reset, LOAD 0x7F, ADD 0x01, both result_ready=1 -> acc=0x80, flag_overflow=0, flag_zero=0; alu_add high exactly one cycle.
REQ-033 acc=0xF0, ADD 0x20 -> without macro acc=0x10, flag_overflow=1; with ALU_SEQ_SATURATE_EN acc=0xFF, flag_overflow=1.
REQ-034 acc=0x05, SUB 0x05 -> acc=0x00, flag_zero=1, flag_overflow=0; then SUB 0x01 -> acc=0xFF (0x00 saturated), flag_overflow=1.
REQ-035 acc=0xAC, AND 0x0F -> acc=0x0C, flag_overflow=0; INV -> acc=0x03; CLR -> acc=0x00, flag_zero=1.
REQ-036 Hold result_ready=0 for 5 cycles while instr_valid=1 -> result_valid stays 1, instr_ready stays 0, acc unchanged; on result_ready=1 FSM returns to IDLE and accepts next instruction one cycle later.
REQ-037 Assert rst during ISSUE of ADD 0x10 on acc=0x01 -> acc=0x00, flags 0, result_valid 0, FSM IDLE, all control lines 0 after that edge.
